sdram_responder: RTL

- Synthesizable responder for the 16-bit SDRAM command bus: the chip side of the link our SDRAM controllers drive.
- Decodes nCS/nRAS/nCAS/nWE, tracks per-bank open rows, honours the mode register's CAS latency, applies DQM byte masks, and serves data from an on-chip block-RAM backing store.
- Used in FPGA-loopback and simulation benches so controller changes can be regression-tested without a physical MT48LC16M16.

---
 rtl/sdram_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
`default_nettype none
// sdram_responder: chip-side model of a 16-bit SDRAM (command decode, bank/row tracking, CL pipeline, DQM, BRAM store).
// Define SDRAM_RESP_TIMING_CHECK_EN to build the tRCD/tRP/tRFC timers and their error checks.
module sdram_responder #(
  parameter int RAM_AW = 12,
  parameter int TRCD   = 2,
  parameter int TRP    = 2,
  parameter int TRFC   = 7
) (
  input  logic        clk,
  input  logic        init,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] SDRAM_DQ_I,
  output logic [15:0] SDRAM_DQ_O,
  output logic [1:0]  SDRAM_DQ_OE,
  output logic        mode_valid,
  output logic [1:0]  cas_lat,
  output logic        err,
  output logic [3:0]  err_code
);
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;

  logic [2:0]        cmd;
  logic              is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_rw, is_cmd;
  logic [3:0]        bank_open;
  logic [12:0]       bank_row [4];
  logic              sel_open, any_open, rw_ok, rd_pending, mode_bad;
  logic              trcd_bad, trp_bad, trfc_bad;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       mem [0:(1<<RAM_AW)-1];
  logic [15:0]       ram_q, data_d1;
  logic [1:0]        mask_d0, mask_d1;
  logic              vld_d0, vld_d1;
  logic [3:0]        new_code;

  assign cmd      = SDRAM_nCS ? CMD_NOP : {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
  assign is_act   = (cmd == CMD_ACT);
  assign is_rd    = (cmd == CMD_RD);
  assign is_wr    = (cmd == CMD_WR);
  assign is_pre   = (cmd == CMD_PRE);
  assign is_ref   = (cmd == CMD_REF);
  assign is_lmr   = (cmd == CMD_LMR);
  assign is_rw    = is_rd | is_wr;
  assign is_cmd   = (cmd != CMD_NOP) && (cmd != CMD_BST);
  assign sel_open = bank_open[SDRAM_BA];
  assign any_open = |bank_open;
  assign rw_ok    = is_rw && mode_valid && sel_open;
  assign mode_bad = (SDRAM_A[2:0] != 3'd0) || !((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3));
  assign ram_addr = RAM_AW'({SDRAM_BA, bank_row[SDRAM_BA], SDRAM_A[8:0]});
  // Any read still in flight, or already on the bus, collides with write data.
  assign rd_pending = vld_d0 || ((cas_lat == 2'd3) && vld_d1) || (SDRAM_DQ_OE != 2'b00);

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam int MAX_T = (TRCD > TRP) ? ((TRCD > TRFC) ? TRCD : TRFC) : ((TRP > TRFC) ? TRP : TRFC);
  localparam int TW    = $clog2(MAX_T) + 1;
  localparam logic [TW-1:0] T_SAT = '1;
  localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

  // Each counter holds cycles elapsed since its event, saturating at all-ones.
  logic [TW-1:0] trcd_cnt [4];
  logic [TW-1:0] trp_cnt  [4];
  logic [TW-1:0] trfc_cnt;

  assign trcd_bad = trcd_cnt[SDRAM_BA] < TW'(TRCD);
  assign trp_bad  = trp_cnt[SDRAM_BA]  < TW'(TRP);
  assign trfc_bad = trfc_cnt           < TW'(TRFC);

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < 4; i++) begin
        trcd_cnt[i] <= T_SAT;
        trp_cnt[i]  <= T_SAT;
      end
      trfc_cnt <= T_SAT;
    end else begin
      for (int i = 0; i < 4; i++) begin
        trcd_cnt[i] <= (trcd_cnt[i] == T_SAT) ? T_SAT : trcd_cnt[i] + T_ONE;
        trp_cnt[i]  <= (trp_cnt[i]  == T_SAT) ? T_SAT : trp_cnt[i]  + T_ONE;
        if (is_act && (SDRAM_BA == 2'(i)))
          trcd_cnt[i] <= T_ONE;
        if ((is_pre && (SDRAM_A[10] || (SDRAM_BA == 2'(i)))) ||
            (rw_ok && SDRAM_A[10] && (SDRAM_BA == 2'(i))))
          trp_cnt[i] <= T_ONE;
      end
      trfc_cnt <= is_ref ? T_ONE : ((trfc_cnt == T_SAT) ? T_SAT : trfc_cnt + T_ONE);
    end
  end
`else
  assign trcd_bad = 1'b0;
  assign trp_bad  = 1'b0;
  assign trfc_bad = 1'b0;
`endif

  // Commands are mutually exclusive, so checking codes in ascending order yields the lowest.
  always_comb begin
    new_code = 4'd0;
    if (is_lmr && any_open)                 new_code = 4'd1;
    else if (is_lmr && mode_bad)            new_code = 4'd2;
    else if (is_act && (sel_open || trp_bad)) new_code = 4'd3;
    else if (is_rw && !mode_valid)          new_code = 4'd4;
    else if (is_rw && !sel_open)            new_code = 4'd5;
    else if (is_wr && rd_pending)           new_code = 4'd6;
    else if (is_ref && any_open)            new_code = 4'd7;
    else if (is_cmd && trfc_bad)            new_code = 4'd8;
    else if (is_rw && trcd_bad)             new_code = 4'd9;
  end

  always_ff @(posedge clk) begin
    if (is_wr && rw_ok) begin
      if (!SDRAM_DQML) mem[ram_addr][7:0]  <= SDRAM_DQ_I[7:0];
      if (!SDRAM_DQMH) mem[ram_addr][15:8] <= SDRAM_DQ_I[15:8];
    end
    if (is_rd && rw_ok)
      ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      bank_open   <= 4'b0000;
      for (int i = 0; i < 4; i++) bank_row[i] <= 13'd0;
      mode_valid  <= 1'b0;
      cas_lat     <= 2'd0;
      err         <= 1'b0;
      err_code    <= 4'd0;
      vld_d0      <= 1'b0;
      vld_d1      <= 1'b0;
      mask_d0     <= 2'b00;
      mask_d1     <= 2'b00;
      data_d1     <= 16'd0;
      SDRAM_DQ_O  <= 16'd0;
      SDRAM_DQ_OE <= 2'b00;
    end else begin
      if (is_act) begin
        bank_open[SDRAM_BA] <= 1'b1;
        bank_row[SDRAM_BA]  <= SDRAM_A;
      end
      if (rw_ok && SDRAM_A[10])
        bank_open[SDRAM_BA] <= 1'b0;
      if (is_pre) begin
        if (SDRAM_A[10]) bank_open <= 4'b0000;
        else             bank_open[SDRAM_BA] <= 1'b0;
      end
      if (is_lmr && !any_open && !mode_bad) begin
        mode_valid <= 1'b1;
        cas_lat    <= SDRAM_A[5:4];
      end
      // Stage 0 aligns with the registered RAM output; stage 1 adds the extra cycle for CL3.
      vld_d0  <= is_rd && rw_ok;
      mask_d0 <= ~{SDRAM_DQMH, SDRAM_DQML};
      vld_d1  <= vld_d0;
      mask_d1 <= mask_d0;
      data_d1 <= ram_q;
      if (cas_lat == 2'd2) begin
        SDRAM_DQ_O  <= vld_d0 ? ram_q   : 16'd0;
        SDRAM_DQ_OE <= vld_d0 ? mask_d0 : 2'b00;
      end else begin
        SDRAM_DQ_O  <= vld_d1 ? data_d1 : 16'd0;
        SDRAM_DQ_OE <= vld_d1 ? mask_d1 : 2'b00;
      end
      if (!err && (new_code != 4'd0)) begin
        err      <= 1'b1;
        err_code <= new_code;
      end
    end
  end
endmodule
`default_nettype wire
